escalonador_processos: RTL and testbench

- Round-robin process scheduler for the SO processor.
- Consumes the context-switch, process-end and I/O-block events from the quantum counter and control unit, and holds a small process table (state plus saved PC per slot).
- Selects the next READY process and drives the PC load (PC to resume plus a one-cycle load strobe) into the PC register mux.
- When no process is runnable, points the PC at the OS idle loop.

---
 rtl/escalonador_processos.sv | 139 +++++++++++++
 tb/tb_escalonador_processos.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/escalonador_processos.sv
// Round-robin process scheduler: keeps a small process table (state + saved PC per slot)
// and drives the PC register mux with the next READY process, or the OS idle loop.
module escalonador_processos #(
  parameter int                  NUM_PROC   = 4,
  parameter int                  PC_WIDTH   = 32,
  parameter int                  ID_WIDTH   = 2,
  parameter logic [PC_WIDTH-1:0] OS_IDLE_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                troca_contexto,
  input  logic [PC_WIDTH-1:0] pc_salvo,
  input  logic                fim_processo,
  input  logic                bloqueio_io,
  input  logic                libera_io,
  input  logic [ID_WIDTH-1:0] libera_id,
  input  logic                cria_processo,
  input  logic [ID_WIDTH-1:0] cria_id,
  input  logic [PC_WIDTH-1:0] cria_pc,
  output logic [PC_WIDTH-1:0] pc_proximo,
  output logic                desvio,
  output logic [ID_WIDTH-1:0] processo_atual,
  output logic                ocioso,
  output logic                ocupado
);

  localparam logic [1:0] FREE    = 2'b00;
  localparam logic [1:0] READY   = 2'b01;
  localparam logic [1:0] RUNNING = 2'b10;
  localparam logic [1:0] BLOCKED = 2'b11;
  localparam logic [ID_WIDTH-1:0] LAST = ID_WIDTH'(NUM_PROC - 1);

  typedef enum logic {IDLE, SEARCH} fsm_t;

  fsm_t                               state, state_nx;
  logic [NUM_PROC-1:0][1:0]           slot_st;
  logic [NUM_PROC-1:0][PC_WIDTH-1:0]  slot_pc;
  logic [ID_WIDTH-1:0]                idx;
  logic [ID_WIDTH-1:0]                cnt;

  logic       any_ready, ev_take, ev_save, start, hit, give_up;
  logic [1:0] ev_st;

  assign ocupado = (state == SEARCH);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    any_ready = 1'b0;
    ev_take   = 1'b0;
    ev_save   = 1'b0;
    ev_st     = FREE;
    start     = 1'b0;
    hit       = 1'b0;
    give_up   = 1'b0;
    for (int i = 0; i < NUM_PROC; i++)
      if (slot_st[i] == READY) any_ready = 1'b1;
    case (state)
      IDLE: begin
        if (!ocioso) begin
          // fim > bloqueio > troca; lower-priority events in the same cycle are dropped
          if (fim_processo) begin
            ev_take = 1'b1;
            ev_st   = FREE;
          end else if (bloqueio_io) begin
            ev_take = 1'b1;
            ev_st   = BLOCKED;
            ev_save = 1'b1;
          end else if (troca_contexto) begin
            ev_take = 1'b1;
            ev_st   = READY;
            ev_save = 1'b1;
          end
          start = ev_take;
        end else begin
          start = any_ready;
        end
      end
      SEARCH: begin
        if (slot_st[idx] == READY) hit = 1'b1;
        else if (cnt == LAST)      give_up = 1'b1;
      end
      default: ;
    endcase
    if (start)           state_nx = SEARCH;
    if (hit || give_up)  state_nx = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_st        <= '0;
      slot_pc        <= '0;
      idx            <= '0;
      cnt            <= '0;
      pc_proximo     <= '0;
      desvio         <= 1'b0;
      processo_atual <= '0;
      ocioso         <= 1'b1;
    end else begin
      desvio <= 1'b0;
      // table updates from outside; the scheduler's own writes below take precedence
      if (libera_io && slot_st[libera_id] == BLOCKED)
        slot_st[libera_id] <= READY;
      if (cria_processo && slot_st[cria_id] == FREE) begin
        slot_st[cria_id] <= READY;
        slot_pc[cria_id] <= cria_pc;
      end
      if (ev_take) begin
        slot_st[processo_atual] <= ev_st;
        if (ev_save) slot_pc[processo_atual] <= pc_salvo;
      end
      if (start) begin
        idx <= processo_atual + ID_WIDTH'(1);
        cnt <= '0;
      end
      if (state == SEARCH) begin
        idx <= idx + ID_WIDTH'(1);
        cnt <= cnt + ID_WIDTH'(1);
      end
      if (hit) begin
        slot_st[idx]   <= RUNNING;
        processo_atual <= idx;
        pc_proximo     <= slot_pc[idx];
        desvio         <= 1'b1;
        ocioso         <= 1'b0;
      end
      if (give_up) begin
        pc_proximo <= OS_IDLE_PC;
        desvio     <= 1'b1;
        ocioso     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_escalonador_processos.sv
// Directed bench for escalonador_processos: a table-level scheduler model checked every
// cycle, plus literal expectations for dispatch PCs, slots and latencies.
module tb_escalonador_processos;

  localparam int NP = 4;
  localparam logic [31:0] IDLE_PC = 32'd0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        troca_contexto = 1'b0;
  logic [31:0] pc_salvo = '0;
  logic        fim_processo = 1'b0;
  logic        bloqueio_io = 1'b0;
  logic        libera_io = 1'b0;
  logic [1:0]  libera_id = '0;
  logic        cria_processo = 1'b0;
  logic [1:0]  cria_id = '0;
  logic [31:0] cria_pc = '0;
  logic [31:0] pc_proximo;
  logic        desvio;
  logic [1:0]  processo_atual;
  logic        ocioso;
  logic        ocupado;

  escalonador_processos #(.NUM_PROC(NP), .PC_WIDTH(32), .ID_WIDTH(2), .OS_IDLE_PC(IDLE_PC)) dut (
    .clock(clock), .reset(reset), .troca_contexto(troca_contexto), .pc_salvo(pc_salvo),
    .fim_processo(fim_processo), .bloqueio_io(bloqueio_io), .libera_io(libera_io),
    .libera_id(libera_id), .cria_processo(cria_processo), .cria_id(cria_id), .cria_pc(cria_pc),
    .pc_proximo(pc_proximo), .desvio(desvio), .processo_atual(processo_atual),
    .ocioso(ocioso), .ocupado(ocupado)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- model: slot table + remaining search cycles ----------------
  int          st[NP];      // 0 free, 1 ready, 2 running, 3 blocked
  logic [31:0] mpc[NP];
  logic [31:0] m_pc;
  int          m_cur;
  bit          m_desvio, m_ocioso;
  int          busy;        // SEARCH cycles left before the dispatch edge
  bit          w_found, rdy, ev;
  int          w;

  always @(posedge clock) begin
    m_desvio = 1'b0;
    if (reset) begin
      for (int i = 0; i < NP; i++) begin st[i] = 0; mpc[i] = '0; end
      m_pc = '0; m_cur = 0; m_ocioso = 1'b1; busy = 0;
    end else begin
      rdy = 1'b0;
      ev  = 1'b0;
      for (int i = 0; i < NP; i++) if (st[i] == 1) rdy = 1'b1;
      if (libera_io && st[libera_id] == 3) st[libera_id] = 1;
      if (cria_processo && st[cria_id] == 0) begin st[cria_id] = 1; mpc[cria_id] = cria_pc; end
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          m_desvio = 1'b1;
          if (w_found) begin st[w] = 2; m_cur = w; m_pc = mpc[w]; m_ocioso = 1'b0; end
          else begin m_pc = IDLE_PC; m_ocioso = 1'b1; end
        end
      end else if (!m_ocioso) begin
        if (fim_processo) begin st[m_cur] = 0; ev = 1'b1; end
        else if (bloqueio_io) begin st[m_cur] = 3; mpc[m_cur] = pc_salvo; ev = 1'b1; end
        else if (troca_contexto) begin st[m_cur] = 1; mpc[m_cur] = pc_salvo; ev = 1'b1; end
      end else begin
        ev = rdy;
      end
      if (ev) begin
        w_found = 1'b0; w = 0; busy = NP;
        for (int k = 1; k <= NP; k++)
          if (!w_found && st[(m_cur + k) % NP] == 1) begin
            w_found = 1'b1; w = (m_cur + k) % NP; busy = k;
          end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("pc_proximo", pc_proximo, m_pc);
      chk("desvio", 32'(desvio), 32'(m_desvio));
      chk("processo_atual", 32'(processo_atual), 32'(m_cur));
      chk("ocioso", 32'(ocioso), 32'(m_ocioso));
      chk("ocupado", 32'(ocupado), 32'(busy > 0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_cria(input logic [1:0] id, input logic [31:0] pc);
    cria_processo = 1'b1; cria_id = id; cria_pc = pc;
    @(negedge clock);
    cria_processo = 1'b0;
  endtask

  task automatic do_libera(input logic [1:0] id);
    libera_io = 1'b1; libera_id = id;
    @(negedge clock);
    libera_io = 1'b0;
  endtask

  task automatic do_ev(input bit f, input bit b, input bit t, input logic [31:0] pcs);
    fim_processo = f; bloqueio_io = b; troca_contexto = t; pc_salvo = pcs;
    @(negedge clock);
    fim_processo = 1'b0; bloqueio_io = 1'b0; troca_contexto = 1'b0;
  endtask

  // cycles from the request edge until desvio is seen; bounded
  task automatic wait_desvio(input string name, input int exp_lat);
    int lat;
    lat = 0;
    while (lat < 20) begin
      @(negedge clock);
      lat++;
      if (desvio) break;
    end
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic expect_out(input string name, input logic [31:0] pc, input int cur, input bit oc);
    chk({name, "_pc"}, pc_proximo, pc);
    chk({name, "_slot"}, 32'(processo_atual), 32'(cur));
    chk({name, "_ocioso"}, 32'(ocioso), 32'(oc));
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk_en = 1'b1;
    expect_out("reset", 32'd0, 0, 1'b1);
    chk("reset_ocupado", 32'(ocupado), 32'd0);
    reset = 1'b0;

    do_cria(2'd1, 32'd400);             wait_desvio("autostart", 2); expect_out("autostart", 32'd400, 1, 1'b0);
    do_cria(2'd2, 32'd500);
    do_ev(0, 0, 1, 32'd403);            wait_desvio("rr1", 1);       expect_out("rr1", 32'd500, 2, 1'b0);
    do_ev(0, 0, 1, 32'd507);            wait_desvio("rr2", 3);       expect_out("rr2", 32'd403, 1, 1'b0);
    do_ev(0, 0, 1, 32'd510);            wait_desvio("rr3", 1);       expect_out("rr3", 32'd507, 2, 1'b0);
    do_ev(1, 0, 1, 32'd555);            wait_desvio("fim", 3);       expect_out("fim", 32'd510, 1, 1'b0);
    do_ev(0, 0, 1, 32'd410);            wait_desvio("lone", 4);      expect_out("lone", 32'd410, 1, 1'b0);
    do_ev(0, 1, 0, 32'd420);            wait_desvio("block", 4);     expect_out("block", IDLE_PC, 1, 1'b1);
    do_ev(0, 0, 1, 32'd999);
    repeat (3) @(negedge clock);
    chk("idle_ignores_troca", 32'(ocupado), 32'd0);
    do_libera(2'd1);                    wait_desvio("libera", 5);    expect_out("libera", 32'd420, 1, 1'b0);
    do_cria(2'd2, 32'd600);
    do_ev(0, 0, 1, 32'd430);            wait_desvio("recria", 1);    expect_out("recria", 32'd600, 2, 1'b0);
    do_cria(2'd1, 32'd777);
    do_ev(0, 0, 1, 32'd605);            wait_desvio("cria_busy", 3); expect_out("cria_busy", 32'd430, 1, 1'b0);
    do_ev(0, 1, 1, 32'd640);            wait_desvio("blk_prio", 1);  expect_out("blk_prio", 32'd605, 2, 1'b0);
    do_ev(0, 0, 1, 32'd650);            wait_desvio("blk_skip", 4);  expect_out("blk_skip", 32'd650, 2, 1'b0);

    do_ev(0, 0, 1, 32'd700);
    chk("search_ocupado", 32'(ocupado), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_desvio", 32'(desvio), 32'd0);
    chk("abort_ocupado", 32'(ocupado), 32'd0);
    expect_out("abort", 32'd0, 0, 1'b1);
    do_libera(2'd1);
    repeat (8) @(negedge clock);
    chk("abort_table_free", 32'(desvio | ocupado), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
